comp_serial_ctrl: RTL and testbench
===================================

COMP_SERIAL_CTRL -- requirements
Module: comp_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; it must be even and at least 2.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have in_valid  input  1  operand pair offered.
REQ-005 SHALL have in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have in_a, in_b  input  WIDTH  operands, unsigned.
REQ-007 SHALL have slice_a, slice_b  output  2  current 2-bit slices driven to the external 2-bit comparator.
REQ-008 SHALL have cmp_l, cmp_e, cmp_g  input  1 each  combinational comparator result for the current slices.
REQ-009 SHALL have out_valid  output  1  result available.
REQ-010 SHALL have out_ready  input  1  result consumed.
REQ-011 SHALL have out_lt, out_eq, out_gt, out_err  output  1 each  final result flags.
REQ-012 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE when in_valid=1, load in_a and in_b into shift registers, set the slice counter to WIDTH/2-1, and enter RUN on the next edge.
REQ-016 SHALL drive slice_a and slice_b from the top 2 bits of the shift registers (MSB slice first) in RUN, and drive 2'b00 in all other states.
REQ-017 SHALL sample cmp_l, cmp_e and cmp_g in the same cycle slices are driven, so the comparator path is purely combinational with zero latency.
REQ-018 SHALL, in each RUN cycle, shift both registers left by 2 and decrement the counter.
REQ-019 SHALL, on the first slice where cmp_e=0, latch that slice's cmp_l or cmp_g as the result (sticky), so later slices cannot change it.
REQ-020 SHALL enter DONE on the edge after the counter=0 slice, or earlier as defined in REQ-030, with the result flags valid on entry.
REQ-021 SHALL set out_eq=1 at completion only when every sampled slice had cmp_e=1.
REQ-022 SHALL, if any sampled cmp_l/cmp_e/cmp_g is not exactly one-hot, set out_err=1 (sticky), clear out_lt, out_eq and out_gt, and finish the operation normally.
REQ-023 SHALL assert out_valid only in DONE, and hold out_valid and all result flags stable while out_ready=0.
REQ-024 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1; a new operand pair is accepted no earlier than the following cycle.
REQ-025 SHALL ignore in_valid outside IDLE; operands are not re-sampled during RUN or DONE.
REQ-026 SHALL, for a full-length compare, assert out_valid WIDTH/2+1 cycles after the accept edge.
REQ-027 SHALL, at WIDTH=2, run a single RUN cycle.

Reset
REQ-028 SHALL, on the edge with rst_n=0, set state=IDLE, shift registers=0, counter=0, and out_valid, out_lt, out_eq, out_gt, out_err and busy all to 0; in_ready=1 after reset.
REQ-029 SHALL abort any operation in progress in RUN or DONE on reset, discard its result, and produce no out_valid afterwards.

Configuration
REQ-030 SHALL, with macro COMP_EARLY_EXIT_EN defined, move from RUN to DONE on the edge after the first slice with cmp_e=0 or with a non-one-hot result, so latency is k+2 cycles from accept for deciding slice index k (0 = MSB slice).
REQ-031 SHALL, with COMP_EARLY_EXIT_EN undefined, always run all WIDTH/2 slices, giving fixed latency WIDTH/2+1, while the result is still taken from the first non-equal slice.

Verification (WIDTH=8; cycles are counted from the accept edge)
REQ-032 SHALL cover in_a=0xA5, in_b=0xA5 -> out_eq=1, out_lt=0, out_gt=0, out_err=0, with out_valid at cycle 5 in both configurations.
REQ-033 SHALL cover in_a=0x80, in_b=0x7F -> out_gt=1, with out_valid at cycle 2 with COMP_EARLY_EXIT_EN and at cycle 5 without it, and with the later slices (a<b at bit level) not altering the result.
REQ-034 SHALL cover in_a=0x12, in_b=0x13 -> out_lt=1 decided on the last slice, with out_valid at cycle 5 in both configurations.
REQ-035 SHALL cover holding out_ready=0 for 3 cycles after out_valid -> flags stable, in_ready=0 and busy=1 throughout, then return to IDLE one cycle after out_ready=1.
REQ-036 SHALL cover rst_n=0 for one edge during RUN at slice 2 -> busy=0, in_ready=1 and no out_valid, and a following compare of 0x00 vs 0x01 gives out_lt=1.
REQ-037 SHALL cover a bench comparator model forcing cmp_l=cmp_g=1 on slice 1 -> out_err=1 with out_lt, out_eq and out_gt all 0, and out_valid at cycle 3 with COMP_EARLY_EXIT_EN or cycle 5 without it.

Source files
------------

// File: rtl/comp_serial_ctrl.sv
// rtl/comp_serial_ctrl.sv - serial MSB-first magnitude compare, 2 bits/cycle via external comparator
// Optional COMP_EARLY_EXIT_EN: leave RUN as soon as the result is decided or a fault is seen.
module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             dec_q, lt_q, gt_q, err_q;
  logic             ov_q, olt_q, oeq_q, ogt_q, oerr_q, busy_q, ir_q;

  logic onehot, take, dec_d, lt_d, gt_d, err_d, finish;

  always_comb begin
    onehot = (cmp_l & ~cmp_e & ~cmp_g) | (~cmp_l & cmp_e & ~cmp_g) | (~cmp_l & ~cmp_e & cmp_g);
    // Only the first clean non-equal slice may set the result; later slices are ignored.
    take   = ~dec_q & onehot & ~cmp_e;
    dec_d  = dec_q | take;
    lt_d   = take ? cmp_l : lt_q;
    gt_d   = take ? cmp_g : gt_q;
    err_d  = err_q | ~onehot;
`ifdef COMP_EARLY_EXIT_EN
    finish = (cnt_q == '0) | ~onehot | ~cmp_e;
`else
    finish = (cnt_q == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      olt_q   <= 1'b0;
      oeq_q   <= 1'b0;
      ogt_q   <= 1'b0;
      oerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      ir_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= CW'(WIDTH / 2 - 1);
            dec_q   <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            err_q   <= 1'b0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            ir_q    <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_q << 2;
          b_q   <= b_q << 2;
          cnt_q <= cnt_q - 1'b1;
          dec_q <= dec_d;
          lt_q  <= lt_d;
          gt_q  <= gt_d;
          err_q <= err_d;
          if (finish) begin
            state_q <= DONE;
            ov_q    <= 1'b1;
            oerr_q  <= err_d;
            olt_q   <= lt_d & ~err_d;
            ogt_q   <= gt_d & ~err_d;
            oeq_q   <= ~dec_d & ~err_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            ir_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ov_q    <= 1'b0;
          busy_q  <= 1'b0;
          ir_q    <= 1'b1;
        end
      endcase
    end
  end

  assign slice_a   = (state_q == RUN) ? a_q[WIDTH-1 -: 2] : 2'b00;
  assign slice_b   = (state_q == RUN) ? b_q[WIDTH-1 -: 2] : 2'b00;
  assign in_ready  = ir_q;
  assign busy      = busy_q;
  assign out_valid = ov_q;
  assign out_lt    = olt_q;
  assign out_eq    = oeq_q;
  assign out_gt    = ogt_q;
  assign out_err   = oerr_q;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// tb/tb_comp_serial_ctrl.sv - bench for comp_serial_ctrl with comparator model and reference model
module tb_comp_serial_ctrl;
  localparam int W = 8;
`ifdef COMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_lt, out_eq, out_gt, out_err, busy;
  logic [1:0]   slice_a, slice_b;
  logic         cmp_l, cmp_e, cmp_g;

  int n_cmp = 0, n_bad = 0;
  int drv_err = -1;
  bit chk_en = 1'b0;

  logic         m_busy = 1'b0;
  int           m_cyc = 0, m_lat = 0, m_err = -1;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [3:0]   m_flags = '0;
  logic         fault;

  comp_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .slice_a(slice_a), .slice_b(slice_b),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g), .out_valid(out_valid),
    .out_ready(out_ready), .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // external 2-bit comparator; can be forced to an illegal l=g=1 code on one slice
  assign fault = m_busy && ((m_cyc - 1) == m_err);
  assign cmp_l = fault | (slice_a < slice_b);
  assign cmp_e = ~fault & (slice_a == slice_b);
  assign cmp_g = fault | (slice_a > slice_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int s = 0; s < W / 2; s++)
      if (((a >> (W - 2 - 2 * s)) & 2'd3) != ((b >> (W - 2 - 2 * s)) & 2'd3)) return s;
    return W / 2 - 1;
  endfunction

  function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    int k;
    k = first_diff(a, b);
    if (!EARLY) return W / 2 + 1;
    if (e >= 0 && e < k) return e + 2;
    return k + 2;
  endfunction

  function automatic logic [3:0] flags_of(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    if (e >= 0 && (!EARLY || e <= first_diff(a, b))) return 4'b0001;
    return {a < b, a == b, a > b, 1'b0};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
      m_err  <= -1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_cyc   <= 1;
        m_a     <= in_a;
        m_b     <= in_b;
        m_err   <= drv_err;
        m_lat   <= lat_of(in_a, in_b, drv_err);
        m_flags <= flags_of(in_a, in_b, drv_err);
      end
    end else if (m_cyc >= m_lat) begin
      if (out_ready) begin
        m_busy <= 1'b0;
        m_err  <= -1;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic         mv;
    logic [W-1:0] ta, tb;
    if (chk_en) begin
      mv = m_busy && (m_cyc >= m_lat);
      ta = '0;
      tb = '0;
      if (m_busy && m_cyc < m_lat) begin
        ta = m_a >> (W - 2 * m_cyc);
        tb = m_b >> (W - 2 * m_cyc);
      end
      chk("busy", busy, m_busy);
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, mv);
      chk("slice_a", slice_a, ta[1:0]);
      chk("slice_b", slice_b, tb[1:0]);
      if (mv) chk("flags", {out_lt, out_eq, out_gt, out_err}, m_flags);
    end
  end

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int e, input int hold, input bit junk,
                       input logic [3:0] xf, input int xlat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; drv_err = e; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      in_a = ~a; in_b = a;
    end else begin
      in_valid = 1'b0;
    end
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, n, xlat);
    chk({nm, " flags"}, {out_lt, out_eq, out_gt, out_err}, xf);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " back idle"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op("eq A5", 8'hA5, 8'hA5, -1, 3, 1'b0, 4'b0100, 5);
    do_op("gt 80/7F", 8'h80, 8'h7F, -1, 0, 1'b0, 4'b0010, EARLY ? 2 : 5);
    do_op("lt 12/13", 8'h12, 8'h13, -1, 0, 1'b1, 4'b1000, 5);

    @(negedge clk);
    in_a = 8'h55; in_b = 8'h55; in_valid = 1'b1; drv_err = -1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("abort no valid", out_valid, 0);
    end

    do_op("lt 00/01", 8'h00, 8'h01, -1, 0, 1'b0, 4'b1000, 5);
    do_op("err s1", 8'h3C, 8'h3C, 1, 0, 1'b0, 4'b0001, EARLY ? 3 : 5);
    do_op("gt FF/00", 8'hFF, 8'h00, -1, 1, 1'b0, 4'b0010, EARLY ? 2 : 5);
    do_op("err s2 late", 8'h40, 8'h00, 2, 0, 1'b0, EARLY ? 4'b0010 : 4'b0001, EARLY ? 2 : 5);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
